jtag_scan_master: RTL and testbench
===================================

// Module: jtag_scan_master
// PURPOSE
//  Host-side sequencer for the TAP controller. Accepts scan commands over a valid/ready port and drives TMS/TDI one bit per TCK edge.
//  Walks the target TAP through reset, IR scans, DR scans and idle runs, and returns the captured TDO bits.
//  Keeps an internal mirror of the TAP state that tracks the target STATE cycle-for-cycle, in the same 4-bit encoding.
// PARAMETERS
//  IR_LEN  4   instruction register length, in bits (>=1)
//  DR_MAX  32  maximum DR scan length, in bits; also the data/response width
//  LEN_W   6   width of CMD_LEN; must satisfy 2**LEN_W > DR_MAX
// PORTS
//  TCK        in   1          scan clock; all state changes on posedge
//  TRST       in   1          asynchronous active-low reset
//  CMD_VALID  in   1          command present
//  CMD_READY  out  1          master idle; command accepted on CMD_VALID & CMD_READY
//  CMD_OP     in   2          00 RESET, 01 IR_SCAN, 10 DR_SCAN, 11 IDLE
//  CMD_LEN    in   LEN_W      DR bits (DR_SCAN) or idle cycles (IDLE); ignored otherwise
//  CMD_DATA   in   DR_MAX     shift-in data, LSB first; IR_SCAN uses [IR_LEN-1:0]
//  TMS        out  1          to target TAP
//  TDI        out  1          serial data to target
//  TDO        in   1          serial data from target, sampled on posedge
//  RSP_VALID  out  1          one-cycle pulse: scan/command complete
//  RSP_DATA   out  DR_MAX     captured TDO bits; [i] = bit sampled on i-th shift edge
//  TAP_STATE  out  4          mirror of target state (0000 TLR ... 1111 UPDATE_IR)
// BEHAVIOUR
//  - Reset (TRST=0, async): TMS=1, TDI=0, TAP_STATE=0000 (TLR), CMD_READY=0, RSP_VALID=0, RSP_DATA=0, FSM=IDLE.
//    CMD_READY rises on the first posedge after TRST is released.
//  - TMS/TDI are registered. The value present at posedge E is consumed by the target at E.
//    TAP_STATE advances at E from that same TMS value using the standard 16-state TAP table.
//  - Accept edge A (CMD_VALID & CMD_READY): CMD_READY drops; the first sequence bit is on TMS for edge A+1.
//  - CMD_READY stays low until the cycle after RSP_VALID; a new command may be accepted at that edge.
//  - Pre-step: a scan or IDLE command issued while TAP_STATE=TLR first drives TMS=0 for one edge (-> RTI).
//  - Sequences, all starting from RTI:
//    - RESET: TMS=1 for 5 edges (-> TLR), then TMS=0 for 1 edge (-> RTI). No pre-step. Total 6 edges.
//    - IR_SCAN: TMS 1,1,0,0 (SEL_DR, SEL_IR, CAP_IR, SHIFT_IR).
//      Then IR_LEN shift edges: TMS=0 except the last (TMS=1 -> EXIT1_IR).
//      Then TMS 1 (UPDATE_IR), 0 (RTI). Total IR_LEN+6 edges.
//    - DR_SCAN: TMS 1,0,0 (SEL_DR, CAP_DR, SHIFT_DR), then N shift edges (last TMS=1 -> EXIT1_DR).
//      Then TMS 1 (UPDATE_DR), 0 (RTI). Total N+5 edges.
//    - IDLE: TMS=0 for N edges (remain in RTI).
//  - Length rules: N = CMD_LEN. N=0 is treated as 1; N>DR_MAX is clamped to DR_MAX. Latched at accept.
//  - Shift edges: TDI = CMD_DATA[i] on the i-th shift edge, i=0..N-1; TDO is captured into RSP_DATA[i] at that edge.
//    TDI=0 outside shift edges. RSP_DATA bits >= N are 0. IR_SCAN returns IR_LEN captured bits.
//  - RSP_VALID pulses for exactly one cycle, after the final edge that reaches RTI.
//    RSP_DATA holds its value until the next command's completion or reset. RESET and IDLE return RSP_DATA=0.
//  - CMD_VALID while busy is ignored; no command is ever queued.
//  - TRST mid-command: immediate abort to reset values. No RSP_VALID for the aborted command.
//  - Invariant: TAP_STATE never reaches PAUSE_DR or PAUSE_IR. Every command ends in RTI (0001).
// TESTING
//  - Pair the master with tap_controller on shared TCK/TRST/TMS; compare TAP_STATE with the target STATE every posedge.
//  - Reset then RESET cmd -> TAP_STATE 0000 x5, then 0001. RSP_VALID after 6 edges. CMD_READY=1 next cycle.
//  - IR_SCAN, CMD_DATA=4'b1010, TDO tied to a 4-bit shift model preloaded 4'b0110.
//    -> TDI sequence 0,1,0,1 on SHIFT_IR edges; RSP_DATA=4'b0110; 10 edges; end at 0001.
//  - DR_SCAN, LEN=32, CMD_DATA=32'hDEADBEEF, TDO looped to TDI -> RSP_DATA=32'hDEADBEEF; 37 edges.
//  - DR_SCAN with LEN=0 -> 1-bit scan (6 edges). LEN=40 -> clamped to 32 (37 edges).
//    IDLE with LEN=5 -> 5 edges at 0001, RSP_VALID, RSP_DATA=0.
//  - Pull TRST low at the 3rd shift edge of a DR_SCAN -> TMS=1, TAP_STATE=0000, no RSP_VALID.
//    After release, a DR_SCAN issued from TLR shows the 1-edge pre-step and then completes normally.

Source files
------------

// File: rtl/jtag_scan_master.sv
// Host-side JTAG sequencer: drives registered TMS/TDI for reset, IR/DR scans and
// idle runs, mirrors the target TAP state and returns the captured TDO bits.
module jtag_scan_master #(
  parameter int IR_LEN = 4,
  parameter int DR_MAX = 32,
  parameter int LEN_W  = 6
) (
  input  logic              tck_i,
  input  logic              trst_ni,
  input  logic              cmdValid_i,
  output logic              cmdReady_o,
  input  logic [1:0]        cmdOp_i,
  input  logic [LEN_W-1:0]  cmdLen_i,
  input  logic [DR_MAX-1:0] cmdData_i,
  output logic              tms_o,
  output logic              tdi_o,
  input  logic              tdo_i,
  output logic              rspValid_o,
  output logic [DR_MAX-1:0] rspData_o,
  output logic [3:0]        tapState_o
);
  localparam int PW = LEN_W + 1;

  typedef enum logic [1:0] {OP_RESET = 2'b00, OP_IR = 2'b01, OP_DR = 2'b10, OP_IDLE = 2'b11} op_e;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;
  typedef enum logic [3:0] {
    TLR = 4'h0, RTI, SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR,
    UPD_DR, SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
  } tap_e;

  typedef struct packed {
    logic          tms;
    logic          tdi;
    logic          shift;
    logic [PW-1:0] idx;
  } bit_t;

  state_e            state_q;
  tap_e              tapState_q, tapNext_d;
  op_e               op_q, cmdOp;
  logic              tms_q, tdi_q, cmdReady_q, rspValid_q, pre_q, pre_d;
  logic [PW-1:0]     n_q, last_q, pos_q, nLen_d, last_d;
  logic [DR_MAX-1:0] data_q, acc_q, rspData_q, capVec;
  bit_t              firstBit, curBit, nextBit;

  // Bit k of a command's TMS/TDI stream; position 0 is the TLR->RTI pre-step when present.
  function automatic bit_t seqBit(input op_e op, input logic pre, input logic [PW-1:0] n,
                                  input logic [DR_MAX-1:0] data, input logic [PW-1:0] k);
    bit_t              b;
    logic [PW-1:0]     kk, hd;
    logic [DR_MAX-1:0] sh;
    b  = '0;
    kk = k - PW'(pre);
    hd = (op == OP_IR) ? PW'(4) : PW'(3);
    sh = '0;
    if (pre && (k == '0)) begin
      b.tms = 1'b0;
    end else begin
      case (op)
        OP_RESET: b.tms = (kk < PW'(5));
        OP_IDLE:  b.tms = 1'b0;
        default: begin
          if (kk < hd) begin
            b.tms = (op == OP_IR) ? (kk < PW'(2)) : (kk == '0);
          end else if (kk < hd + n) begin
            b.shift = 1'b1;
            b.idx   = kk - hd;
            b.tms   = (b.idx == n - PW'(1));
            sh      = data >> b.idx;
            b.tdi   = sh[0];
          end else begin
            b.tms = (kk == hd + n);
          end
        end
      endcase
    end
    return b;
  endfunction

  function automatic tap_e tapStep(input tap_e s, input logic tms);
    tap_e n;
    n = s;
    case (s)
      TLR:      n = tms ? TLR      : RTI;
      RTI:      n = tms ? SEL_DR   : RTI;
      SEL_DR:   n = tms ? SEL_IR   : CAP_DR;
      CAP_DR:   n = tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: n = tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: n = tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: n = tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: n = tms ? UPD_DR   : SHIFT_DR;
      UPD_DR:   n = tms ? SEL_DR   : RTI;
      SEL_IR:   n = tms ? TLR      : CAP_IR;
      CAP_IR:   n = tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: n = tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: n = tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: n = tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: n = tms ? UPD_IR   : SHIFT_IR;
      UPD_IR:   n = tms ? SEL_DR   : RTI;
    endcase
    return n;
  endfunction

  always_comb begin
    cmdOp = op_e'(cmdOp_i);
    pre_d = (cmdOp != OP_RESET) && (tapState_q == TLR);
    if (cmdOp == OP_IR)                nLen_d = PW'(IR_LEN);
    else if (cmdLen_i == '0)           nLen_d = PW'(1);
    else if (int'(cmdLen_i) > DR_MAX)  nLen_d = PW'(DR_MAX);
    else                               nLen_d = PW'(cmdLen_i);
    case (cmdOp)
      OP_RESET: last_d = PW'(5);
      OP_IR:    last_d = nLen_d + PW'(5) + PW'(pre_d);
      OP_DR:    last_d = nLen_d + PW'(4) + PW'(pre_d);
      default:  last_d = nLen_d - PW'(1) + PW'(pre_d);
    endcase
    firstBit  = seqBit(cmdOp, pre_d, nLen_d, cmdData_i, '0);
    curBit    = seqBit(op_q, pre_q, n_q, data_q, pos_q);
    nextBit   = seqBit(op_q, pre_q, n_q, data_q, pos_q + PW'(1));
    capVec    = acc_q | (DR_MAX'(tdo_i) << curBit.idx);
    tapNext_d = tapStep(tapState_q, tms_q);
  end

  // Each edge consumes the bit already on TMS/TDI and loads the next one, so the
  // mirror and the target advance on the same value.
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      state_q    <= ST_IDLE;
      tapState_q <= TLR;
      tms_q      <= 1'b1;
      tdi_q      <= 1'b0;
      cmdReady_q <= 1'b0;
      rspValid_q <= 1'b0;
      rspData_q  <= '0;
      op_q       <= OP_RESET;
      pre_q      <= 1'b0;
      n_q        <= '0;
      last_q     <= '0;
      pos_q      <= '0;
      data_q     <= '0;
      acc_q      <= '0;
    end else begin
      tapState_q <= tapNext_d;
      rspValid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmdValid_i && cmdReady_q) begin
            cmdReady_q <= 1'b0;
            op_q       <= cmdOp;
            pre_q      <= pre_d;
            n_q        <= nLen_d;
            last_q     <= last_d;
            data_q     <= cmdData_i;
            pos_q      <= '0;
            acc_q      <= '0;
            tms_q      <= firstBit.tms;
            tdi_q      <= firstBit.tdi;
            state_q    <= ST_RUN;
          end else begin
            cmdReady_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (curBit.shift) acc_q <= capVec;
          if (pos_q == last_q) begin
            rspValid_q <= 1'b1;
            rspData_q  <= curBit.shift ? capVec : acc_q;
            tms_q      <= 1'b0;
            tdi_q      <= 1'b0;
            state_q    <= ST_DONE;
          end else begin
            pos_q <= pos_q + PW'(1);
            tms_q <= nextBit.tms;
            tdi_q <= nextBit.tdi;
          end
        end
        default: begin
          cmdReady_q <= 1'b1;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmdReady_o = cmdReady_q;
  assign tms_o      = tms_q;
  assign tdi_o      = tdi_q;
  assign rspValid_o = rspValid_q;
  assign rspData_o  = rspData_q;
  assign tapState_o = tapState_q;

endmodule

// File: tb/tb_jtag_scan_master.sv
// Bench for jtag_scan_master: a target TAP model and TDO source run beside the
// DUT while a table of commands is applied, plus a mid-scan TRST abort sequence.
module tb_jtag_scan_master;
  localparam int IR_LEN = 4;
  localparam int DR_MAX = 32;
  localparam int LEN_W  = 6;

  localparam logic [3:0] S_TLR = 4'h0, S_RTI = 4'h1, S_SELDR = 4'h2, S_CAPDR = 4'h3,
                         S_SHDR = 4'h4, S_EX1DR = 4'h5, S_PADR = 4'h6, S_EX2DR = 4'h7,
                         S_UPDR = 4'h8, S_SELIR = 4'h9, S_CAPIR = 4'hA, S_SHIR = 4'hB,
                         S_EX1IR = 4'hC, S_PAIR = 4'hD, S_EX2IR = 4'hE, S_UPIR = 4'hF;

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  len;
    logic [31:0] data;
    logic        loopMode;
    logic [3:0]  preload;
    int          expEdges;
    logic [31:0] expRsp;
    int          expShifts;
    logic [31:0] expTdi;
    logic        expFirstTms;
  } vec_t;

  logic              tck = 1'b0;
  logic              trstN = 1'b0;
  logic              cmdValid = 1'b0;
  logic              cmdReady;
  logic [1:0]        cmdOp = 2'b00;
  logic [LEN_W-1:0]  cmdLen = '0;
  logic [DR_MAX-1:0] cmdData = '0;
  logic              tms, tdi, tdo, rspValid;
  logic [DR_MAX-1:0] rspData;
  logic [3:0]        tapState;

  logic [3:0] tbState;
  logic [3:0] sr;
  logic [3:0] srPre = 4'h0;
  logic       loopMode = 1'b0;

  int errors = 0;
  int checks = 0;

  vec_t vecs[8];

  always #5 tck = ~tck;

  jtag_scan_master #(.IR_LEN(IR_LEN), .DR_MAX(DR_MAX), .LEN_W(LEN_W)) dut (
    .tck_i(tck), .trst_ni(trstN), .cmdValid_i(cmdValid), .cmdReady_o(cmdReady),
    .cmdOp_i(cmdOp), .cmdLen_i(cmdLen), .cmdData_i(cmdData), .tms_o(tms), .tdi_o(tdi),
    .tdo_i(tdo), .rspValid_o(rspValid), .rspData_o(rspData), .tapState_o(tapState)
  );

  assign tdo = loopMode ? tdi : sr[0];

  // Reference IEEE 1149.1 TAP state table for the modelled target.
  function automatic logic [3:0] tapModel(input logic [3:0] s, input logic m);
    case (s)
      S_TLR:   return m ? S_TLR   : S_RTI;
      S_RTI:   return m ? S_SELDR : S_RTI;
      S_SELDR: return m ? S_SELIR : S_CAPDR;
      S_CAPDR: return m ? S_EX1DR : S_SHDR;
      S_SHDR:  return m ? S_EX1DR : S_SHDR;
      S_EX1DR: return m ? S_UPDR  : S_PADR;
      S_PADR:  return m ? S_EX2DR : S_PADR;
      S_EX2DR: return m ? S_UPDR  : S_SHDR;
      S_UPDR:  return m ? S_SELDR : S_RTI;
      S_SELIR: return m ? S_TLR   : S_CAPIR;
      S_CAPIR: return m ? S_EX1IR : S_SHIR;
      S_SHIR:  return m ? S_EX1IR : S_SHIR;
      S_EX1IR: return m ? S_UPIR  : S_PAIR;
      S_PAIR:  return m ? S_EX2IR : S_PAIR;
      S_EX2IR: return m ? S_UPIR  : S_SHIR;
      default: return m ? S_SELDR : S_RTI;
    endcase
  endfunction

  // Target model: TAP state plus a 4-bit shift register that reloads while parked.
  always @(posedge tck or negedge trstN) begin
    if (!trstN) begin
      tbState <= S_TLR;
      sr      <= 4'h0;
    end else begin
      if (tbState == S_RTI || tbState == S_TLR) sr <= srPre;
      else if (tbState == S_SHDR || tbState == S_SHIR) sr <= {tdi, sr[3:1]};
      tbState <= tapModel(tbState, tms);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one command, then scrambles the command inputs with CMD_VALID held
  // high until the response to show that a busy master ignores them.
  task automatic applyStimulus(input vec_t v, output int edges, output logic [31:0] rsp,
                               output int shifts, output logic [31:0] tdiBits,
                               output logic firstTms, output int tapErrs,
                               output logic readyAtRsp, output logic readyAfter,
                               output logic validAfter);
    int   waitCnt;
    logic done;
    edges = 0; rsp = '0; shifts = 0; tdiBits = '0; firstTms = 1'b0; tapErrs = 0;
    readyAtRsp = 1'b1; readyAfter = 1'b0; validAfter = 1'b1; done = 1'b0; waitCnt = 0;
    @(negedge tck);
    while (cmdReady !== 1'b1 && waitCnt < 50) begin
      @(negedge tck);
      waitCnt++;
    end
    loopMode = v.loopMode;
    srPre    = v.preload;
    cmdValid = 1'b1;
    cmdOp    = v.op;
    cmdLen   = v.len;
    cmdData  = v.data;
    @(posedge tck);
    @(negedge tck);
    firstTms = tms;
    cmdOp    = 2'($urandom_range(0, 3));
    cmdLen   = 6'($urandom_range(0, 63));
    cmdData  = $urandom();
    while (!done && edges < 100) begin
      if (tapState !== tbState || tapState == S_PADR || tapState == S_PAIR) tapErrs++;
      if (tbState == S_SHDR || tbState == S_SHIR) begin
        if (shifts < 32) tdiBits[shifts] = tdi;
        shifts++;
      end
      @(posedge tck);
      @(negedge tck);
      edges++;
      if (rspValid === 1'b1) begin
        done       = 1'b1;
        rsp        = rspData;
        readyAtRsp = cmdReady;
        if (tapState !== tbState) tapErrs++;
      end
    end
    cmdValid = 1'b0;
    if (!done) edges = -1;
    @(negedge tck);
    readyAfter = cmdReady;
    validAfter = rspValid;
  endtask

  initial begin
    int          edges, shifts, tapErrs;
    logic [31:0] rsp, tdiBits;
    logic        firstTms, readyAtRsp, readyAfter, validAfter, rspSeen;
    int          waitCnt;
    vec_t        pv;

    //          op     len    data           loop preload edges rsp           shifts tdi           firstTms
    vecs[0] = '{2'b00, 6'd0,  32'h0000_0000, 1'b1, 4'h0, 6,  32'h0000_0000, 0,  32'h0000_0000, 1'b1};
    vecs[1] = '{2'b01, 6'd0,  32'hFFFF_FFFA, 1'b0, 4'h6, 10, 32'h0000_0006, 4,  32'h0000_000A, 1'b1};
    vecs[2] = '{2'b10, 6'd32, 32'hDEAD_BEEF, 1'b1, 4'h0, 37, 32'hDEAD_BEEF, 32, 32'hDEAD_BEEF, 1'b1};
    vecs[3] = '{2'b10, 6'd0,  32'h0000_0001, 1'b1, 4'h0, 6,  32'h0000_0001, 1,  32'h0000_0001, 1'b1};
    vecs[4] = '{2'b10, 6'd40, 32'h1234_5678, 1'b1, 4'h0, 37, 32'h1234_5678, 32, 32'h1234_5678, 1'b1};
    vecs[5] = '{2'b11, 6'd5,  32'hFFFF_FFFF, 1'b1, 4'h0, 5,  32'h0000_0000, 0,  32'h0000_0000, 1'b0};
    vecs[6] = '{2'b10, 6'd8,  32'hFFFF_FFA5, 1'b1, 4'h0, 13, 32'h0000_00A5, 8,  32'h0000_00A5, 1'b1};
    vecs[7] = '{2'b01, 6'd0,  32'h0000_0003, 1'b0, 4'h9, 10, 32'h0000_0009, 4,  32'h0000_0003, 1'b1};

    repeat (2) @(negedge tck);
    checkOutput("reset.tms", 32'(tms), 32'd1);
    checkOutput("reset.tdi", 32'(tdi), 32'd0);
    checkOutput("reset.tapState", 32'(tapState), 32'(S_TLR));
    checkOutput("reset.cmdReady", 32'(cmdReady), 32'd0);
    checkOutput("reset.rspValid", 32'(rspValid), 32'd0);
    checkOutput("reset.rspData", rspData, 32'd0);
    trstN = 1'b1;
    @(negedge tck);
    checkOutput("reset.readyRise", 32'(cmdReady), 32'd1);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], edges, rsp, shifts, tdiBits, firstTms, tapErrs, readyAtRsp,
                    readyAfter, validAfter);
      checkOutput($sformatf("v%0d.edges", i), 32'(edges), 32'(vecs[i].expEdges));
      checkOutput($sformatf("v%0d.rspData", i), rsp, vecs[i].expRsp);
      checkOutput($sformatf("v%0d.shifts", i), 32'(shifts), 32'(vecs[i].expShifts));
      checkOutput($sformatf("v%0d.tdiBits", i), tdiBits, vecs[i].expTdi);
      checkOutput($sformatf("v%0d.firstTms", i), 32'(firstTms), 32'(vecs[i].expFirstTms));
      checkOutput($sformatf("v%0d.tapTrack", i), 32'(tapErrs), 32'd0);
      checkOutput($sformatf("v%0d.endState", i), 32'(tapState), 32'(S_RTI));
      checkOutput($sformatf("v%0d.readyAtRsp", i), 32'(readyAtRsp), 32'd0);
      checkOutput($sformatf("v%0d.readyAfter", i), 32'(readyAfter), 32'd1);
      checkOutput($sformatf("v%0d.pulseOnce", i), 32'(validAfter), 32'd0);
    end

    // Abort a DR scan with TRST right after its third shift edge.
    waitCnt = 0;
    @(negedge tck);
    while (cmdReady !== 1'b1 && waitCnt < 50) begin
      @(negedge tck);
      waitCnt++;
    end
    loopMode = 1'b1;
    cmdValid = 1'b1;
    cmdOp    = 2'b10;
    cmdLen   = 6'd8;
    cmdData  = 32'h0000_00FF;
    @(posedge tck);
    @(negedge tck);
    cmdValid = 1'b0;
    repeat (6) @(posedge tck);
    checkOutput("abort.inShift", 32'(tbState), 32'(S_SHDR));
    #1 trstN = 1'b0;
    #1;
    checkOutput("abort.tms", 32'(tms), 32'd1);
    checkOutput("abort.tapState", 32'(tapState), 32'(S_TLR));
    checkOutput("abort.cmdReady", 32'(cmdReady), 32'd0);
    checkOutput("abort.rspData", rspData, 32'd0);
    rspSeen = 1'b0;
    repeat (3) begin
      @(negedge tck);
      if (rspValid !== 1'b0) rspSeen = 1'b1;
    end
    trstN = 1'b1;
    repeat (5) begin
      @(negedge tck);
      if (rspValid !== 1'b0) rspSeen = 1'b1;
    end
    checkOutput("abort.noRsp", 32'(rspSeen), 32'd0);
    checkOutput("abort.holdTlr", 32'(tapState), 32'(S_TLR));

    pv = '{2'b10, 6'd4, 32'h0000_0009, 1'b1, 4'h0, 10, 32'h0000_0009, 4, 32'h0000_0009, 1'b0};
    applyStimulus(pv, edges, rsp, shifts, tdiBits, firstTms, tapErrs, readyAtRsp,
                  readyAfter, validAfter);
    checkOutput("prestep.edges", 32'(edges), 32'(pv.expEdges));
    checkOutput("prestep.firstTms", 32'(firstTms), 32'(pv.expFirstTms));
    checkOutput("prestep.rspData", rsp, pv.expRsp);
    checkOutput("prestep.tdiBits", tdiBits, pv.expTdi);
    checkOutput("prestep.tapTrack", 32'(tapErrs), 32'd0);
    checkOutput("prestep.endState", 32'(tapState), 32'(S_RTI));
    checkOutput("prestep.readyAfter", 32'(readyAfter), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
